sap1_sequencer: RTL

Microprogrammed sequencer for the SAP-1 datapath (pc, memory/MAR, ir, reg_a, reg_b, adder on a shared 8-bit bus).
- Steps a 6-T-state fetch/execute ring and decodes ir opcode into the 12-bit control word that drives load/enable strobes and the hlt line to the clock block.
- Adds run/step/halt control, an instruction-complete pulse and a retired-instruction counter, so the CPU can be single-stepped from board switches.

---
 rtl/sap1_pkg.sv | 39 +++
 rtl/sap1_microrom.sv | 63 ++++++
 rtl/sap1_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 sequencer: opcodes, control-word bit positions,
// T-state encodings and the run-state enum.
package sap1_pkg;

  localparam int unsigned CW_W = 12;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned CB_HLT       = 11;
  localparam int unsigned CB_PC_INC    = 10;
  localparam int unsigned CB_PC_EN     = 9;
  localparam int unsigned CB_MAR_LOAD  = 8;
  localparam int unsigned CB_MEM_EN    = 7;
  localparam int unsigned CB_IR_LOAD   = 6;
  localparam int unsigned CB_IR_EN     = 5;
  localparam int unsigned CB_A_LOAD    = 4;
  localparam int unsigned CB_A_EN      = 3;
  localparam int unsigned CB_B_LOAD    = 2;
  localparam int unsigned CB_ADDER_SUB = 1;
  localparam int unsigned CB_ADDER_EN  = 0;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

endpackage

// File: rtl/sap1_microrom.sv
// Combinational microcode ROM: (T-state, opcode) -> 12-bit control word.
module sap1_microrom
  import sap1_pkg::*;
(
  input  logic [2:0]      stage,
  input  logic [3:0]      opcode,
  output logic [CW_W-1:0] word
);

  always_comb begin
    word = '0;
    case (stage)
      T0: begin
        word[CB_PC_EN]    = 1'b1;
        word[CB_MAR_LOAD] = 1'b1;
      end
      T1: word[CB_PC_INC] = 1'b1;
      T2: begin
        word[CB_MEM_EN]  = 1'b1;
        word[CB_IR_LOAD] = 1'b1;
      end
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            word[CB_IR_EN]    = 1'b1;
            word[CB_MAR_LOAD] = 1'b1;
          end
          OP_HLT:  word[CB_HLT] = 1'b1;
          default: word = '0;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            word[CB_MEM_EN] = 1'b1;
            word[CB_A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            word[CB_MEM_EN] = 1'b1;
            word[CB_B_LOAD] = 1'b1;
          end
          default: word = '0;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD: begin
            word[CB_ADDER_EN] = 1'b1;
            word[CB_A_LOAD]   = 1'b1;
          end
          OP_SUB: begin
            word[CB_ADDER_EN]  = 1'b1;
            word[CB_A_LOAD]    = 1'b1;
            word[CB_ADDER_SUB] = 1'b1;
          end
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/sap1_sequencer.sv
// SAP-1 sequencer: run/step/halt state machine, T-state ring, retire pulse and
// retired-instruction counter around the microcode ROM.
module sap1_sequencer
  import sap1_pkg::*;
#(
  parameter bit AUTORUN   = 1'b1,
  parameter bit EARLY_END = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      opcode,
  input  logic            run_en,
  input  logic            step_req,
  input  logic            clr_halt,
  output logic [CW_W-1:0] ctrl_out,
  output logic [2:0]      stage,
  output logic            halted,
  output logic            instr_done,
  output logic [7:0]      instr_cnt
);

  state_t          state;
  logic [CW_W-1:0] rom_word;
  logic            active;
  logic            last_stage;

  sap1_microrom u_rom (
    .stage  (stage),
    .opcode (opcode),
    .word   (rom_word)
  );

  assign active = (state == S_RUN) || (state == S_STEP);
  assign halted = (state == S_HALTED);

  always_comb begin
    last_stage = (stage == T5) || (EARLY_END && (opcode == OP_LDA) && (stage == T4));
  end

  // Outputs are forced to zero while rst is low, even when AUTORUN resets into RUN.
  always_comb begin
    ctrl_out   = '0;
    instr_done = 1'b0;
    if (rst) begin
      if (active) begin
        ctrl_out   = rom_word;
        instr_done = last_stage;
      end else if (state == S_HALTED) begin
        ctrl_out[CB_HLT] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= AUTORUN ? S_RUN : S_IDLE;
      stage     <= T0;
      instr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stage <= T0;
          if (run_en)        state <= S_RUN;
          else if (step_req) state <= S_STEP;
        end
        S_RUN, S_STEP: begin
          if ((stage == T3) && (opcode == OP_HLT)) begin
            state <= S_HALTED;
            stage <= T0;
          end else if (last_stage) begin
            stage     <= T0;
            instr_cnt <= instr_cnt + 8'd1;
            if ((state == S_STEP) || !run_en) state <= S_IDLE;
          end else begin
            stage <= stage + 3'd1;
          end
        end
        S_HALTED: begin
          stage <= T0;
          if (clr_halt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
